// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
//   Run-control sequencer for a synchronous down-counter. A single-clock
//   prescaler produces a step enable every TICK_DIV cycles; the sequencer
//   loads, runs, pauses/resumes and reports completion of the count.
//
// Parameters
//   TICK_DIV    clk cycles per count step (>= 2)
//   COUNT_W     width of count and load_val
//
// Ports
//   clk          system clock, all state updates on rising edge
//   rst          synchronous active-high reset
//   load_val     value loaded on start and on auto-reload
//   start        1-cycle pulse, (re)starts the count from load_val
//   pause        level, holds the count while high
//   clear        1-cycle pulse, aborts and returns to IDLE
//   auto_reload  level, wrap to load_val instead of stopping at zero
//   count        registered count value
//   tick         registered strobe, count shows a newly stepped value
//   done_pulse   registered strobe, count first shows 0 (step or zero start)
//   done         level, state is DONE
//   running      level, state is RUN
//   state        IDLE=00, RUN=01, PAUSE=10, DONE=11
// -----------------------------------------------------------------------------
module countdown_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int COUNT_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               start,
  input  logic               pause,
  input  logic               clear,
  input  logic               auto_reload,
  output logic [COUNT_W-1:0] count,
  output logic               tick,
  output logic               done_pulse,
  output logic               done,
  output logic               running,
  output logic [1:0]         state
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [COUNT_W-1:0] count_d;
  logic [COUNT_W-1:0] step_val;
  logic               tick_d;
  logic               done_pulse_d;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers: prescaler, count and the two strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q      <= '0;
      count      <= '0;
      tick       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      count      <= count_d;
      tick       <= tick_d;
      done_pulse <= done_pulse_d;
    end
  end

  // Next-state / next-datapath logic. Priority: clear > start > pause > step.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    pre_d        = pre_q;
    count_d      = count;
    tick_d       = 1'b0;
    done_pulse_d = 1'b0;
    step_val     = (count == '0) ? load_val : count - 1'b1;

    if (clear) begin
      state_d = IDLE;
      pre_d   = '0;
      count_d = '0;
    end else if (start) begin
      pre_d = '0;
      if (load_val == '0) begin
        // A zero start completes immediately; no step, so no tick.
        state_d      = DONE;
        count_d      = '0;
        done_pulse_d = 1'b1;
      end else begin
        state_d = RUN;
        count_d = load_val;
      end
    end else begin
      unique case (state_q)
        RUN, PAUSE: begin
          if (pause) begin
            // Entering or staying in PAUSE: prescaler frozen, step suppressed.
            state_d = PAUSE;
          end else begin
            // Resuming counts as a running cycle, so a pause delays the next
            // step by exactly the number of cycles pause was sampled high.
            state_d = RUN;
            if (pre_q == PRE_MAX) begin
              pre_d   = '0;
              count_d = step_val;
              tick_d  = 1'b1;
              if (step_val == '0) begin
                done_pulse_d = 1'b1;
                if (!auto_reload) state_d = DONE;
              end
            end else begin
              pre_d = pre_q + 1'b1;
            end
          end
        end
        default: ;  // IDLE and DONE hold until start or clear
      endcase
    end
  end

  // Output decode.
  always_comb begin
    state   = state_q;
    done    = (state_q == DONE);
    running = (state_q == RUN);
  end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Run-control sequencer for the lab's 4-bit synchronous down-counter datapath. It replaces the derived divided clock with a single-clock prescaler tick enable, so all logic stays on the 50 MHz board clock. It loads a start value, runs, pauses and resumes the count, and reports completion. It sits between the board switches/keys and the seven-segment/LED display of the count.

## Interface
Parameters:
- TICK_DIV, 50_000_000: system-clock cycles per count step; must be ≥ 2
- COUNT_W, 4: width of the count and of the load value

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- load_val  input  COUNT_W  value loaded on start and on auto-reload
- start  input  1  single-cycle pulse; (re)starts the count from load_val
- pause  input  1  level; while high, the count is held
- clear  input  1  single-cycle pulse; aborts the count and returns to IDLE
- auto_reload  input  1  level; when high, the count wraps to load_val instead of stopping
- count  output  COUNT_W  current count value, registered
- tick  output  1  registered strobe, high in the cycle count shows a new stepped value
- done_pulse  output  1  registered strobe, high in the cycle count first shows 0 after a step or a zero start
- done  output  1  level, high while state is DONE
- running  output  1  level, high while state is RUN
- state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

## Operation
- Input priority each cycle: rst > clear > start > pause > prescaler step.
- Prescaler pre, 0..TICK_DIV-1:
  - Increments only in RUN when pause is low.
  - Wraps to 0 at TICK_DIV-1 and issues a step.
  - Holds its value in PAUSE. Cleared on start, clear and rst.
- A step in RUN:
  - count≠0: count ← count-1.
  - count==0 (reachable only with auto_reload): count ← load_val.
  - tick goes high with the new value.
- A step that makes count 0:
  - done_pulse goes high.
  - auto_reload=0: next state is DONE.
  - auto_reload=1: state stays RUN.
- auto_reload is sampled at the step edge.
- State transitions:
  - IDLE: start → RUN with count ← load_val. If load_val==0, go directly to DONE with done_pulse high.
  - RUN: pause=1 → PAUSE, and no step occurs that cycle, even if pre is at TICK_DIV-1. Zero reached with auto_reload=0 → DONE.
  - PAUSE: pause=0 → RUN, with pre continuing from its held value.
  - DONE: holds count=0. start → reload as from IDLE.
  - Any state: start → reload and RUN, or DONE for a zero load_val. clear → IDLE with count=0.
- load_val changes while running take effect only at the next start or auto-reload.

## Timing
- Reset values: count=0, pre=0, state=IDLE, tick=0, done_pulse=0, done=0, running=0.
- rst asserted mid-count: all of the above take effect at the next edge. No partial step.
- Start latency:
  - start sampled at edge E → count=load_val and state=RUN visible after E.
  - First step at edge E+TICK_DIV, then every TICK_DIV cycles of un-paused RUN.
- Pause: each cycle spent in PAUSE, plus the cycle pause is first sampled, delays the next step by exactly one cycle.
- Strobe widths:
  - tick and done_pulse are exactly one cycle wide.
  - done_pulse coincides with tick on a stepped zero.
  - done_pulse is alone on a zero-value start.
- Simultaneous events:
  - clear+start → clear wins.
  - start+pause → start wins; RUN is entered and pause is evaluated next cycle.
  - pause at a step boundary → step suppressed.

## Test plan
All scenarios use TICK_DIV=4 and COUNT_W=4.
- Reset: hold rst 2 cycles → count=0, state=00, all strobes and levels 0. Release; 10 idle cycles → no change.
- One-shot count: load_val=3, auto_reload=0, start at edge E.
  - count=3 after E; 2 at E+4; 1 at E+8; 0 at E+12.
  - tick high at each of those edges; done_pulse at E+12; state=DONE and done=1 from E+12 until clear.
- Pause: load_val=5, start at E, pause high over edges E+2..E+7 → first step at E+10 (count=4), not E+4. Steps then every 4 cycles.
- Auto-reload: load_val=2, auto_reload=1 → count 2,1,0,2,1,0 at 4-cycle spacing. done_pulse with each 0; done never set; running stays 1.
- Zero start: load_val=0, start → state=DONE next cycle, done_pulse for 1 cycle, tick=0.
- Aborts:
  - clear+start together mid-RUN → IDLE, count=0.
  - start alone mid-RUN with load_val=7 → count=7 next cycle, next step 4 cycles later.
  - rst mid-RUN → reset values next edge.
